// File: rtl/score_renderer.sv
// Score/high-score keeper that draws both values as 3x5 glyphs into the pixel stream.
// Two-stage pipeline: stage 1 decodes geometry and picks the digit, stage 2 looks up the font.
module score_renderer #(
  parameter int X0          = 8,
  parameter int Y0          = 8,
  parameter int SCALE_SHIFT = 1,
  parameter int ZERO_BLANK  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_tick,
  input  logic        game_over,
  input  logic [15:0] score,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        display_on,
  output logic        pixel,
  output logic [15:0] hi_score,
  output logic        new_high
);
  localparam logic [9:0] XL   = 10'(X0);
  localparam logic [9:0] XR   = 10'(X0 + (16 << SCALE_SHIFT));
  localparam logic [9:0] YS_T = 10'(Y0);
  localparam logic [9:0] YS_B = 10'(Y0 + (5 << SCALE_SHIFT));
  localparam logic [9:0] YH_T = 10'(Y0 + (6 << SCALE_SHIFT));
  localparam logic [9:0] YH_B = 10'(Y0 + (11 << SCALE_SHIFT));

  logic [15:0] r_disp_score;
  logic [15:0] r_hi_score;
  logic        r_new_high;

  logic        r_in_d1;
  logic [3:0]  r_nib_d1;
  logic [2:0]  r_grow_d1;
  logic [1:0]  r_gcol_d1;
  logic        r_de_d1;
  logic        r_blank_d1;
  logic        r_pixel;

  logic        w_in_x, w_in_s, w_in_h;
  logic [9:0]  w_dx, w_dy;
  logic [1:0]  w_k, w_gcol;
  logic [2:0]  w_grow;
  logic [15:0] w_val;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [2:0]  w_frow;
  logic        w_bit;

  assign w_in_x = (hpos >= XL) && (hpos < XR);
  assign w_in_s = (vpos >= YS_T) && (vpos < YS_B);
  assign w_in_h = (vpos >= YH_T) && (vpos < YH_B);
  assign w_dx   = hpos - XL;
  assign w_dy   = w_in_h ? (vpos - YH_T) : (vpos - YS_T);
  assign w_k    = 2'(w_dx >> (SCALE_SHIFT + 2));
  assign w_gcol = 2'(w_dx >> SCALE_SHIFT);
  assign w_grow = 3'(w_dy >> SCALE_SHIFT);
  // The hi row shows the live high score; the score row shows the per-frame snapshot.
  assign w_val  = w_in_h ? r_hi_score : r_disp_score;

  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b0;
    case (w_k)
      2'd0: begin w_nib = w_val[15:12]; w_blank = (w_val[15:12] == 4'd0); end
      2'd1: begin w_nib = w_val[11:8];  w_blank = (w_val[15:8]  == 8'd0); end
      2'd2: begin w_nib = w_val[7:4];   w_blank = (w_val[15:4]  == 12'd0); end
      default: begin w_nib = w_val[3:0]; w_blank = 1'b0; end
    endcase
    if (ZERO_BLANK == 0) w_blank = 1'b0;
  end

  // Font rows, MSB = leftmost column; A..F fall through to an all-dark glyph.
  always_comb begin
    w_frow = 3'd0;
    case (r_nib_d1)
      4'd0: case (r_grow_d1) 3'd0: w_frow = 3'd7; 3'd1: w_frow = 3'd5; 3'd2: w_frow = 3'd5; 3'd3: w_frow = 3'd5; 3'd4: w_frow = 3'd7; default: w_frow = 3'd0; endcase
      4'd1: case (r_grow_d1) 3'd0: w_frow = 3'd2; 3'd1: w_frow = 3'd6; 3'd2: w_frow = 3'd2; 3'd3: w_frow = 3'd2; 3'd4: w_frow = 3'd7; default: w_frow = 3'd0; endcase
      4'd2: case (r_grow_d1) 3'd0: w_frow = 3'd7; 3'd1: w_frow = 3'd1; 3'd2: w_frow = 3'd7; 3'd3: w_frow = 3'd4; 3'd4: w_frow = 3'd7; default: w_frow = 3'd0; endcase
      4'd3: case (r_grow_d1) 3'd0: w_frow = 3'd7; 3'd1: w_frow = 3'd1; 3'd2: w_frow = 3'd7; 3'd3: w_frow = 3'd1; 3'd4: w_frow = 3'd7; default: w_frow = 3'd0; endcase
      4'd4: case (r_grow_d1) 3'd0: w_frow = 3'd5; 3'd1: w_frow = 3'd5; 3'd2: w_frow = 3'd7; 3'd3: w_frow = 3'd1; 3'd4: w_frow = 3'd1; default: w_frow = 3'd0; endcase
      4'd5: case (r_grow_d1) 3'd0: w_frow = 3'd7; 3'd1: w_frow = 3'd4; 3'd2: w_frow = 3'd7; 3'd3: w_frow = 3'd1; 3'd4: w_frow = 3'd7; default: w_frow = 3'd0; endcase
      4'd6: case (r_grow_d1) 3'd0: w_frow = 3'd7; 3'd1: w_frow = 3'd4; 3'd2: w_frow = 3'd7; 3'd3: w_frow = 3'd5; 3'd4: w_frow = 3'd7; default: w_frow = 3'd0; endcase
      4'd7: case (r_grow_d1) 3'd0: w_frow = 3'd7; 3'd1: w_frow = 3'd1; 3'd2: w_frow = 3'd1; 3'd3: w_frow = 3'd1; 3'd4: w_frow = 3'd1; default: w_frow = 3'd0; endcase
      4'd8: case (r_grow_d1) 3'd0: w_frow = 3'd7; 3'd1: w_frow = 3'd5; 3'd2: w_frow = 3'd7; 3'd3: w_frow = 3'd5; 3'd4: w_frow = 3'd7; default: w_frow = 3'd0; endcase
      4'd9: case (r_grow_d1) 3'd0: w_frow = 3'd7; 3'd1: w_frow = 3'd5; 3'd2: w_frow = 3'd7; 3'd3: w_frow = 3'd1; 3'd4: w_frow = 3'd7; default: w_frow = 3'd0; endcase
      default: w_frow = 3'd0;
    endcase
  end

  always_comb begin
    case (r_gcol_d1)
      2'd0:    w_bit = w_frow[2];
      2'd1:    w_bit = w_frow[1];
      2'd2:    w_bit = w_frow[0];
      default: w_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_score <= 16'd0;
      r_hi_score   <= 16'd0;
      r_new_high   <= 1'b0;
      r_in_d1      <= 1'b0;
      r_nib_d1     <= 4'd0;
      r_grow_d1    <= 3'd0;
      r_gcol_d1    <= 2'd0;
      r_de_d1      <= 1'b0;
      r_blank_d1   <= 1'b0;
      r_pixel      <= 1'b0;
    end else begin
      if (game_tick) r_disp_score <= score;
      if (game_over && (score > r_hi_score)) r_hi_score <= score;
      r_new_high <= game_over && (score > r_hi_score);
      r_in_d1    <= w_in_x && (w_in_s || w_in_h);
      r_nib_d1   <= w_nib;
      r_grow_d1  <= w_grow;
      r_gcol_d1  <= w_gcol;
      r_de_d1    <= display_on;
      r_blank_d1 <= w_blank;
      r_pixel    <= w_bit & r_in_d1 & ~r_blank_d1 & r_de_d1;
    end
  end

  assign pixel    = r_pixel;
  assign hi_score = r_hi_score;
  assign new_high = r_new_high;
endmodule
